sram_8x64_arbiter: RTL and testbench
====================================

// Module: sram_8x64_arbiter
// PURPOSE
//  Shares one nangate45_8x64_1P_bit single-port SRAM macro between NUM_REQ requesters.
//  Round-robin grants at most one access per cycle, drives the macro pins, and returns read data one cycle after grant.
//  Macro pins are held X-free: when ce is low every pin is 0.
//  Sits between the client blocks and the SRAM macro instance.
// PARAMETERS
//  NUM_REQ     2   number of requesters (2..8)
//  BITS        8   data/mask width, matches macro
//  WORD_DEPTH  64  macro depth
//  ADDR_WIDTH  6   clog2(WORD_DEPTH)
// PORTS
//  clk          in   1                clock; macro shares it
//  reset        in   1                synchronous, active-high
//  req_valid_i  in   NUM_REQ          per-requester command valid
//  req_ready_o  out  NUM_REQ          per-requester grant; accept = valid&ready
//  req_we_i     in   NUM_REQ          1=write, 0=read
//  req_addr_i   in   NUM_REQ*ADDR_W   word address, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//  req_data_i   in   NUM_REQ*BITS     write data
//  req_mask_i   in   NUM_REQ*BITS     write bit mask (1 = bit written)
//  rsp_valid_o  out  NUM_REQ          read data valid, one-hot, 1 cycle
//  rsp_data_o   out  BITS             read data, meaningful only with rsp_valid_o
//  init_done_o  out  1                controller accepting traffic
//  sram_ce_o, sram_we_o  out 1        to macro ce_in / we_in
//  sram_addr_o  out  ADDR_WIDTH       to macro addr_in
//  sram_wd_o, sram_mask_o out BITS    to macro wd_in / w_mask_in
//  sram_rd_i    in   BITS             from macro rd_out
// BEHAVIOUR
//  - States: INIT -> RUN. reset forces INIT, clears pointers; reset mid-access drops it, no response issued.
//  - Reset values: req_ready_o=0, rsp_valid_o=0, init_done_o=0, rsp_data_o=0, all sram_* pins=0.
//  - RUN: init_done_o=1; grant is combinational from req_valid_i; req_ready_o one-hot or zero.
//  - Round-robin: priority starts at requester (last_grant+1) mod NUM_REQ; last_grant updates only on accept.
//    After reset last_grant=NUM_REQ-1, so requester 0 has top priority.
//  - Accept in cycle T: sram_ce_o=1, other sram_* driven from winner in T (combinational); macro samples at end of T.
//  - Read accepted in T: rsp_valid_o[winner]=1 in T+1, rsp_data_o=sram_rd_i in T+1; no hold beyond T+1.
//  - Write accepted: no response; macro merges (wd & mask)|(old & ~mask).
//  - Read-after-write same address, back-to-back cycles: read returns the new data (macro ordering).
//  - Full throughput: one accept per cycle, no bubbles; a requester keeping valid high is served at least once per NUM_REQ accepts.
//  - No grant: sram_ce_o=0, all sram_* pins 0; rsp_data_o is not captured from rd_out (macro drives X).
//  - Requester must keep command stable while valid&!ready; dropping valid is allowed.
// CONFIGURATION
//  SRAM_ARB_INIT_CLEAR_EN defined:
//    INIT sweeps addresses 0..WORD_DEPTH-1, one per cycle: ce=1, we=1, wd=0, mask=all-ones.
//    Sweep takes 64 cycles after reset deasserts; RUN and init_done_o=1 from the following cycle; req_ready_o=0 throughout INIT.
//  Undefined: INIT lasts exactly one cycle, then RUN; memory content undefined until written.
// STRUCTURE
//  sram_arb_pkg: state enum (ST_INIT, ST_RUN), default widths, clog2 helper for index width.
//  Sub-module rr_arbiter: NUM_REQ req vector + advance strobe -> one-hot grant, internal last_grant pointer.
//  Top: state/init counter, pin mux, one-cycle response pipe (valid one-hot + read flag).
// TESTING
//  1 Reset, CLEAR_EN on: init_done_o rises exactly 65 cycles after reset falls; read all 64 addrs -> 8'h00.
//  2 Req0 write addr 5 data A5 mask FF, next cycle read addr 5 -> rsp_valid_o=01 one cycle later, data A5.
//  3 Mask: write 3C mask FF, then write FF mask 0F to addr 9 -> read 9 returns 3F.
//  4 Both valid every cycle, reads to different addrs -> grants alternate 01,10,01,...; req0 first; no idle cycles.
//  5 Assert reset while req1 read accepted -> no rsp_valid_o next cycle; all outputs at reset values.
//  6 Idle 10 cycles -> sram_ce_o=0 and all sram_* pins 0; rsp_valid_o stays 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types, default widths and width helpers for the SRAM arbiter slice.
package sram_arb_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_BITS       = 8;
    localparam int DEF_WORD_DEPTH = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Index width that stays at least one bit for single-entry vectors.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/sram_8x64_arbiter_if.sv
// Client-side request/response bus plus SRAM macro pins; directions named from the arbiter's view.
interface sram_8x64_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BITS       = DEF_BITS,
    parameter int ADDR_WIDTH = clog2(DEF_WORD_DEPTH)
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ-1:0]            req_we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*BITS-1:0]       req_data_i;
    logic [NUM_REQ*BITS-1:0]       req_mask_i;
    logic [NUM_REQ-1:0]            rsp_valid_o;
    logic [BITS-1:0]               rsp_data_o;
    logic                          init_done_o;
    logic                          sram_ce_o;
    logic                          sram_we_o;
    logic [ADDR_WIDTH-1:0]         sram_addr_o;
    logic [BITS-1:0]               sram_wd_o;
    logic [BITS-1:0]               sram_mask_o;
    logic [BITS-1:0]               sram_rd_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_data_i, req_mask_i, sram_rd_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, init_done_o,
               sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o, sram_mask_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_data_i, req_mask_i, sram_rd_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, init_done_o,
               sram_ce_o, sram_we_o, sram_addr_o, sram_wd_o, sram_mask_o
    );

endinterface

// File: rtl/sram_8x64_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer moves to the winner only when advance is strobed.
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] win_idx;
    logic             found;

    // Search starts one past the last winner and wraps.
    always_comb begin
        gnt_o   = '0;
        win_idx = last_q;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(last_q) + 1 + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req_i[k]) begin
                gnt_o[k] = 1'b1;
                win_idx  = IDX_W'(k);
                found    = 1'b1;
            end
        end
        last_d = (adv_i && found) ? win_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= IDX_W'(NUM_REQ - 1);
        else       last_q <= last_d;
    end

endmodule

// File: rtl/sram_8x64_arbiter.sv
// Round-robin sharing of one 8x64 single-port SRAM macro; define SRAM_ARB_INIT_CLEAR_EN
// to have INIT sweep the whole array to zero before traffic is accepted.
module sram_8x64_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BITS       = DEF_BITS,
    parameter int WORD_DEPTH = DEF_WORD_DEPTH,
    parameter int ADDR_WIDTH = clog2(WORD_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    sram_8x64_arbiter_if.slave  bus
);
    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    req_vld;
    logic [NUM_REQ-1:0]    gnt;
    logic                  accept;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [BITS-1:0]       win_wd;
    logic [BITS-1:0]       win_mask;
    logic [NUM_REQ-1:0]    gnt_p1_q;
    logic                  vld_p1_q;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam int CNT_W = clog2(WORD_DEPTH + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign req_vld = (state_q == ST_RUN) ? bus.req_valid_i : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req_i (req_vld),
        .adv_i (accept),
        .gnt_o (gnt)
    );

    assign accept          = |gnt;
    assign bus.req_ready_o = gnt;

    always_comb begin
        win_we   = 1'b0;
        win_addr = '0;
        win_wd   = '0;
        win_mask = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
                win_we   = bus.req_we_i[r];
                win_addr = bus.req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
                win_wd   = bus.req_data_i[r*BITS +: BITS];
                win_mask = bus.req_mask_i[r*BITS +: BITS];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.init_done_o = 1'b0;
        bus.sram_ce_o   = 1'b0;
        bus.sram_we_o   = 1'b0;
        bus.sram_addr_o = '0;
        bus.sram_wd_o   = '0;
        bus.sram_mask_o = '0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef SRAM_ARB_INIT_CLEAR_EN
                // Count 0 is a quiet lead-in cycle; counts 1..WORD_DEPTH clear address count-1.
                if (cnt_q != '0) begin
                    bus.sram_ce_o   = 1'b1;
                    bus.sram_we_o   = 1'b1;
                    bus.sram_addr_o = ADDR_WIDTH'(cnt_q - CNT_W'(1));
                    bus.sram_mask_o = '1;
                end
                if (cnt_q == CNT_W'(WORD_DEPTH)) state_d = ST_RUN;
                else                             cnt_d   = cnt_q + CNT_W'(1);
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                bus.init_done_o = 1'b1;
                if (accept) begin
                    bus.sram_ce_o   = 1'b1;
                    bus.sram_we_o   = win_we;
                    bus.sram_addr_o = win_addr;
                    bus.sram_wd_o   = win_wd;
                    bus.sram_mask_o = win_mask;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Stage p1: macro read data arrives the cycle after the accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            gnt_p1_q <= '0;
            vld_p1_q <= 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_p1_q <= gnt;
            vld_p1_q <= accept & ~win_we;
`ifdef SRAM_ARB_INIT_CLEAR_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.rsp_valid_o = vld_p1_q ? gnt_p1_q : '0;
    assign bus.rsp_data_o  = vld_p1_q ? bus.sram_rd_i : '0;

endmodule

// File: tb/tb_sram_8x64_arbiter.sv
// Scoreboard bench for sram_8x64_arbiter with a behavioural 8x64 macro model;
// follows SRAM_ARB_INIT_CLEAR_EN the same way the RTL does.
module tb_sram_8x64_arbiter;
    localparam int N  = 2;
    localparam int B  = 8;
    localparam int AW = 6;
    localparam int D  = 64;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam int INIT_LAT = 65;
`else
    localparam int INIT_LAT = 1;
`endif

    typedef struct {
        int           due;
        logic [N-1:0] vec;
        logic [B-1:0] data;
        bit           chk_d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    sram_8x64_arbiter_if #(.NUM_REQ(N), .BITS(B), .ADDR_WIDTH(AW)) bus ();

    sram_8x64_arbiter #(.NUM_REQ(N), .BITS(B), .WORD_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port macro: masked write, registered read, garbage when not reading.
    logic [B-1:0] mem [D];
    bit seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < D; i++) mem[i] <= B'($urandom);
            seeded <= 1'b1;
            bus.sram_rd_i <= B'($urandom);
        end else if (bus.sram_ce_o) begin
            if (bus.sram_we_o)
                mem[bus.sram_addr_o] <= (bus.sram_wd_o & bus.sram_mask_o) |
                                        (mem[bus.sram_addr_o] & ~bus.sram_mask_o);
            bus.sram_rd_i <= bus.sram_we_o ? B'($urandom) : mem[bus.sram_addr_o];
        end else begin
            bus.sram_rd_i <= B'($urandom);
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t q[$];
    logic [B-1:0] ref_mem [D];
    bit known [D];
    int ref_last = N - 1;
    bit exp_run = 1'b0;
    bit rst_prev = 1'b0;
    logic [N-1:0] g_last = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [N-1:0] eg;
        logic [AW-1:0] a;
        int w;
        exp_t e;
        eg = '0;
        w  = -1;
        if (rst_prev) begin
            check_eq("rst_ready", 32'(bus.req_ready_o), 0);
            check_eq("rst_init_done", 32'(bus.init_done_o), 0);
            check_eq("rst_pins", {8'h0, bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o,
                                  bus.sram_wd_o, bus.sram_mask_o}, 0);
        end else begin
            if (exp_run)
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (ref_last + 1 + i) % N;
                    if (w < 0 && bus.req_valid_i[k]) w = k;
                end
            if (w >= 0) eg[w] = 1'b1;
            check_eq("grant", 32'(bus.req_ready_o), 32'(eg));
            check_eq("init_done", 32'(bus.init_done_o), 32'(exp_run));
            if (w >= 0) begin
                a = bus.req_addr_i[w*AW +: AW];
                check_eq("sram_ce", 32'(bus.sram_ce_o), 1);
                check_eq("sram_addr", 32'(bus.sram_addr_o), 32'(a));
                check_eq("sram_we", 32'(bus.sram_we_o), 32'(bus.req_we_i[w]));
                if (bus.req_we_i[w]) begin
                    check_eq("sram_wd", 32'(bus.sram_wd_o), 32'(bus.req_data_i[w*B +: B]));
                    check_eq("sram_mask", 32'(bus.sram_mask_o), 32'(bus.req_mask_i[w*B +: B]));
                    ref_mem[a] = (bus.req_data_i[w*B +: B] & bus.req_mask_i[w*B +: B]) |
                                 (ref_mem[a] & ~bus.req_mask_i[w*B +: B]);
                    known[a] = known[a] | (bus.req_mask_i[w*B +: B] == '1);
                end else if (!reset) begin
                    e.due = cyc + 1; e.vec = eg; e.data = ref_mem[a]; e.chk_d = known[a];
                    q.push_back(e);
                end
                ref_last = w;
            end else if (exp_run) begin
                check_eq("idle_pins", {8'h0, bus.sram_ce_o, bus.sram_we_o, bus.sram_addr_o,
                                       bus.sram_wd_o, bus.sram_mask_o}, 0);
            end
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check_eq("rsp_valid", 32'(bus.rsp_valid_o), 32'(e.vec));
            if (e.chk_d) check_eq("rsp_data", 32'(bus.rsp_data_o), 32'(e.data));
        end else begin
            check_eq("rsp_idle_valid", 32'(bus.rsp_valid_o), 0);
            check_eq("rsp_idle_data", 32'(bus.rsp_data_o), 0);
        end
        g_last = eg;
    endtask

    task automatic tick();
        bit rp;
        @(negedge clk);
        monitor();
        rp = reset;
        @(posedge clk);
        #1;
        rst_prev = rp;
        cyc++;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        reset = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.init_done_o) break;
            @(posedge clk);
            #1;
            cyc++;
            n++;
        end
        check_eq("init_latency", 32'(n), 32'(INIT_LAT));
        if (n >= 200) begin
            $display("FAIL init_timeout cyc=%0d got %0d expected %0d", cyc, n, INIT_LAT);
            $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
            $fatal(1);
        end
`ifdef SRAM_ARB_INIT_CLEAR_EN
        for (int i = 0; i < D; i++) begin ref_mem[i] = '0; known[i] = 1'b1; end
`endif
        @(posedge clk);
        #1;
        cyc++;
        rst_prev = 1'b0;
        exp_run  = 1'b1;
    endtask

    task automatic drive(input int r, input bit v, input bit we, input int addr,
                         input logic [B-1:0] data, input logic [B-1:0] mask);
        bus.req_valid_i[r]          = v;
        bus.req_we_i[r]             = we;
        bus.req_addr_i[r*AW +: AW]  = AW'(addr);
        bus.req_data_i[r*B +: B]    = data;
        bus.req_mask_i[r*B +: B]    = mask;
    endtask

    task automatic idle(input int n);
        bus.req_valid_i = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end
        reset = 1'b1;
        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.req_mask_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_prev = 1'b1;
        tick();

        // Reset release, then read every address back.
        wait_init();
        for (int i = 0; i < D; i++) begin
            drive(0, 1'b1, 1'b0, i, 8'h00, 8'h00);
            tick();
        end
        idle(2);

        // Write then back-to-back read of the same address.
        drive(0, 1'b1, 1'b1, 5, 8'hA5, 8'hFF); tick();
        drive(0, 1'b1, 1'b0, 5, 8'h00, 8'h00); tick();
        idle(2);

        // Partial mask merge.
        drive(0, 1'b1, 1'b1, 9, 8'h3C, 8'hFF); tick();
        drive(0, 1'b1, 1'b1, 9, 8'hFF, 8'h0F); tick();
        drive(0, 1'b1, 1'b0, 9, 8'h00, 8'h00); tick();
        idle(2);

        // Reset lands while requester 1 has a read accepted.
        bus.req_valid_i = '0;
        drive(1, 1'b1, 1'b0, 9, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        exp_run  = 1'b0;
        ref_last = N - 1;
        q.delete();
        tick();
        bus.req_valid_i = '0;
        wait_init();

        // Both requesters reading continuously: strict alternation from requester 0.
        drive(0, 1'b1, 1'b0, 5, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b0, 9, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int r = 0; r < N; r++)
                if (g_last[r]) bus.req_addr_i[r*AW +: AW] = AW'(r * 16 + i);
        end

        // Idle period.
        idle(10);

        // Random mixed traffic; a command is held while valid and not granted.
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < N; r++)
                if (!(bus.req_valid_i[r] && !g_last[r]))
                    drive(r, 1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), B'($urandom),
                          ($urandom_range(0, 1) != 0) ? 8'hFF : B'($urandom));
            tick();
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
